// File: rtl/zion_issue_ctrl.sv
// zion_issue_ctrl: single-entry issue stage with a register scoreboard and saturating stall counter.
// Optional feature: define ZION_ISSUE_WB_BYPASS_EN to let a same-cycle writeback release a hazard.
module zion_issue_ctrl #(
  parameter int RF_NUM  = 32,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [2:0]         id_unit,
  input  logic [4:0]         id_op,
  input  logic [3:0]         id_mop,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic [4:0]         id_rd,
  input  logic [1:0]         id_s1src,
  input  logic [1:0]         id_s2src,
  input  logic [31:0]        id_ins,
  output logic [2:0]         iss_valid,
  input  logic [2:0]         iss_ready,
  output logic [4:0]         iss_op,
  output logic [3:0]         iss_mop,
  output logic [4:0]         iss_rs1,
  output logic [4:0]         iss_rs2,
  output logic [4:0]         iss_rd,
  output logic [1:0]         iss_s1src,
  output logic [1:0]         iss_s2src,
  output logic [31:0]        iss_ins,
  input  logic               wb_valid,
  input  logic [4:0]         wb_rd,
  input  logic               flush,
  output logic [RF_NUM-1:0]  sb_busy,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [1:0] SrcInt = 2'd2;

  typedef enum logic {
    Empty,
    Held
  } stateT;

  stateT             state;
  stateT             stateNext;
  logic [2:0]        heldUnit;
  logic [RF_NUM-1:0] busyView;
  logic [RF_NUM-1:0] setVec;
  logic [RF_NUM-1:0] clrVec;
  logic [RF_NUM-1:0] busyNext;
  logic              hazard;
  logic              execUnit;
  logic              fire;
  logic              retire;
  logic              leave;
  logic              load;

  // Scoreboard update vectors; register 0 is never tracked.
  always_comb begin
    setVec = '0;
    clrVec = '0;
    if (wb_valid && (wb_rd != 5'd0)) begin
      clrVec[wb_rd] = 1'b1;
    end
    if (fire && (iss_rd != 5'd0)) begin
      setVec[iss_rd] = 1'b1;
    end
    busyNext    = (sb_busy & ~clrVec) | setVec;
    busyNext[0] = 1'b0;
  end

  // Hazard view of the scoreboard, optionally releasing the register being written back now.
  always_comb begin
`ifdef ZION_ISSUE_WB_BYPASS_EN
    busyView = sb_busy & ~clrVec;
`else
    busyView = sb_busy;
`endif
    hazard = ((iss_s1src == SrcInt) && (iss_rs1 != 5'd0) && busyView[iss_rs1]) ||
             ((iss_s2src == SrcInt) && (iss_rs2 != 5'd0) && busyView[iss_rs2]) ||
             ((iss_rd != 5'd0) && busyView[iss_rd]);
  end

  always_comb begin
    iss_valid = 3'b000;
    execUnit  = (heldUnit == 3'd1) || (heldUnit == 3'd2) || (heldUnit == 3'd3);
    if ((state == Held) && !hazard && !flush) begin
      case (heldUnit)
        3'd1:    iss_valid = 3'b001;
        3'd2:    iss_valid = 3'b010;
        3'd3:    iss_valid = 3'b100;
        default: iss_valid = 3'b000;
      endcase
    end
    fire     = |(iss_valid & iss_ready);
    // Non-executing instructions drain once their operands are clear, with no scoreboard effect.
    retire   = (state == Held) && !hazard && !flush && !execUnit;
    leave    = fire || retire;
    id_ready = rst_n && ((state == Empty) || leave) && !flush;
    load     = id_valid && id_ready;
  end

  always_comb begin
    stateNext = state;
    if (flush) begin
      stateNext = Empty;
    end else if (load) begin
      stateNext = Held;
    end else if (leave) begin
      stateNext = Empty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= Empty;
      sb_busy   <= '0;
      stall_cnt <= '0;
    end else begin
      state   <= stateNext;
      sb_busy <= busyNext;
      if ((state == Held) && hazard && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end
    end
  end

  // Held fields only change on acceptance, so they stay stable while waiting on a unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      heldUnit  <= '0;
      iss_op    <= '0;
      iss_mop   <= '0;
      iss_rs1   <= '0;
      iss_rs2   <= '0;
      iss_rd    <= '0;
      iss_s1src <= '0;
      iss_s2src <= '0;
      iss_ins   <= '0;
    end else if (load) begin
      heldUnit  <= id_unit;
      iss_op    <= id_op;
      iss_mop   <= id_mop;
      iss_rs1   <= id_rs1;
      iss_rs2   <= id_rs2;
      iss_rd    <= id_rd;
      iss_s1src <= id_s1src;
      iss_s2src <= id_s2src;
      iss_ins   <= id_ins;
    end
  end

endmodule

// File: tb/tb_zion_issue_ctrl.sv
// tb_zion_issue_ctrl: directed scenarios plus randomized traffic against a behavioural model of zion_issue_ctrl.
module tb_zion_issue_ctrl;

  localparam logic [1:0] NON = 2'd0;
  localparam logic [1:0] IMM = 2'd1;
  localparam logic [1:0] INT = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [2:0]  id_unit;
  logic [4:0]  id_op;
  logic [3:0]  id_mop;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [1:0]  id_s1src;
  logic [1:0]  id_s2src;
  logic [31:0] id_ins;
  logic [2:0]  iss_valid;
  logic [2:0]  iss_ready;
  logic [4:0]  iss_op;
  logic [3:0]  iss_mop;
  logic [4:0]  iss_rs1;
  logic [4:0]  iss_rs2;
  logic [4:0]  iss_rd;
  logic [1:0]  iss_s1src;
  logic [1:0]  iss_s2src;
  logic [31:0] iss_ins;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [31:0] sb_busy;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0]  unit;
    logic [4:0]  op;
    logic [3:0]  mop;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [31:0] ins;
  } instT;

  // Behavioural model state: one optional held instruction, a busy set, a stall count.
  bit          mHeld;
  instT        mInst;
  logic [31:0] mBusy;
  int          mStall;

  always #5 clk = ~clk;

  zion_issue_ctrl #(.RF_NUM(32), .STALL_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready), .id_unit(id_unit),
    .id_op(id_op), .id_mop(id_mop), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_s1src(id_s1src), .id_s2src(id_s2src), .id_ins(id_ins),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_op(iss_op), .iss_mop(iss_mop), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_s1src(iss_s1src), .iss_s2src(iss_s2src), .iss_ins(iss_ins),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .sb_busy(sb_busy), .stall_cnt(stall_cnt)
  );

  function automatic instT mk(input logic [2:0] u, input logic [4:0] op, input logic [3:0] mop,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [1:0] s1, input logic [1:0] s2, input logic [31:0] ins);
    instT i;
    i.unit = u; i.op = op; i.mop = mop; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
    i.s1 = s1; i.s2 = s2; i.ins = ins;
    return i;
  endfunction

  function automatic logic [59:0] fieldsOf(input instT i);
    return {i.op, i.mop, i.rs1, i.rs2, i.rd, i.s1, i.s2, i.ins};
  endfunction

  function automatic logic [59:0] dutFields();
    return {iss_op, iss_mop, iss_rs1, iss_rs2, iss_rd, iss_s1src, iss_s2src, iss_ins};
  endfunction

  function automatic bit isExec(input logic [2:0] u);
    return (u >= 3'd1) && (u <= 3'd3);
  endfunction

  // Operand/destination conflict with the pending set seen this cycle.
  function automatic bit mHazard(input instT i, input logic [31:0] busy, input bit wv, input logic [4:0] wr);
    logic [31:0] b;
    b = busy;
`ifdef ZION_ISSUE_WB_BYPASS_EN
    if (wv && wr != 5'd0) b[wr] = 1'b0;
`endif
    return (i.s1 == INT && i.rs1 != 5'd0 && b[i.rs1]) ||
           (i.s2 == INT && i.rs2 != 5'd0 && b[i.rs2]) ||
           (i.rd != 5'd0 && b[i.rd]);
  endfunction

  task automatic applyStimulus(input bit v, input instT i);
    id_valid = v;
    id_unit  = i.unit;
    id_op    = i.op;
    id_mop   = i.mop;
    id_rs1   = i.rs1;
    id_rs2   = i.rs2;
    id_rd    = i.rd;
    id_s1src = i.s1;
    id_s2src = i.s2;
    id_ins   = i.ins;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, mk(0, 0, 0, 0, 0, 0, NON, NON, 0));
    iss_ready = 3'b000;
    wb_valid  = 1'b0;
    wb_rd     = 5'd0;
    flush     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyIdle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mHeld  = 0;
    mInst  = '0;
    mBusy  = '0;
    mStall = 0;
  endtask

  task automatic test_reset();
    applyIdle();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #3;
    checks++;
    if (iss_valid !== 3'b000) begin failures++; $display("[TB] FAIL reset_iss_valid: got %b expected 000", iss_valid); end
    checks++;
    if (sb_busy !== 32'h0) begin failures++; $display("[TB] FAIL reset_sb_busy: got %h expected 0", sb_busy); end
    checks++;
    if (stall_cnt !== 16'h0) begin failures++; $display("[TB] FAIL reset_stall_cnt: got %h expected 0", stall_cnt); end
    checks++;
    if (dutFields() !== 60'h0) begin failures++; $display("[TB] FAIL reset_fields: got %h expected 0", dutFields()); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (id_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_release_ready: got %b expected 1", id_ready); end
    tick();
  endtask

  task automatic test_basic_issue();
    instT a;
    a = mk(3'd1, 5'd1, 4'd0, 5'd1, 5'd2, 5'd5, INT, INT, 32'h002082B3);
    applyStimulus(1'b1, a);
    iss_ready = 3'b111;
    #1;
    checks++;
    if (id_ready !== 1'b1) begin failures++; $display("[TB] FAIL basic_accept: got %b expected 1", id_ready); end
    checks++;
    if (iss_valid !== 3'b000) begin failures++; $display("[TB] FAIL basic_no_early_issue: got %b expected 000", iss_valid); end
    tick();
    applyStimulus(1'b0, a);
    #1;
    checks++;
    if (iss_valid !== 3'b001) begin failures++; $display("[TB] FAIL basic_issue: got %b expected 001", iss_valid); end
    checks++;
    if (dutFields() !== fieldsOf(a)) begin failures++; $display("[TB] FAIL basic_fields: got %h expected %h", dutFields(), fieldsOf(a)); end
    tick();
    checks++;
    if (sb_busy !== 32'h0000_0020) begin failures++; $display("[TB] FAIL basic_busy_set: got %h expected 00000020", sb_busy); end
  endtask

  task automatic test_wb_bypass();
    instT b;
    b = mk(3'd1, 5'd2, 4'd0, 5'd5, 5'd0, 5'd6, INT, IMM, 32'h00528313);
    applyStimulus(1'b1, b);
    #1;
    checks++;
    if (id_ready !== 1'b1) begin failures++; $display("[TB] FAIL bypass_accept: got %b expected 1", id_ready); end
    tick();
    applyStimulus(1'b0, b);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (iss_valid !== 3'b000) begin failures++; $display("[TB] FAIL bypass_hold_%0d: got %b expected 000", i, iss_valid); end
      checks++;
      if (stall_cnt !== 16'(i)) begin failures++; $display("[TB] FAIL bypass_stall_%0d: got %0d expected %0d", i, stall_cnt, i); end
      @(posedge clk);
      #1;
    end
    wb_valid = 1'b1;
    wb_rd    = 5'd5;
    #1;
    checks++;
`ifdef ZION_ISSUE_WB_BYPASS_EN
    if (iss_valid !== 3'b001) begin failures++; $display("[TB] FAIL bypass_wb_cycle: got %b expected 001", iss_valid); end
`else
    if (iss_valid !== 3'b000) begin failures++; $display("[TB] FAIL bypass_wb_cycle: got %b expected 000", iss_valid); end
`endif
    tick();
    wb_valid = 1'b0;
    wb_rd    = 5'd0;
    #1;
`ifdef ZION_ISSUE_WB_BYPASS_EN
    checks++;
    if (stall_cnt !== 16'd4) begin failures++; $display("[TB] FAIL bypass_stall_final: got %0d expected 4", stall_cnt); end
    checks++;
    if (sb_busy !== 32'h0000_0040) begin failures++; $display("[TB] FAIL bypass_busy: got %h expected 00000040", sb_busy); end
`else
    checks++;
    if (iss_valid !== 3'b001) begin failures++; $display("[TB] FAIL bypass_late_issue: got %b expected 001", iss_valid); end
    checks++;
    if (stall_cnt !== 16'd5) begin failures++; $display("[TB] FAIL bypass_stall_final: got %0d expected 5", stall_cnt); end
    tick();
    checks++;
    if (sb_busy !== 32'h0000_0040) begin failures++; $display("[TB] FAIL bypass_busy: got %h expected 00000040", sb_busy); end
`endif
  endtask

  task automatic test_muldiv_backpressure();
    instT m;
    instT other;
    doReset();
    m     = mk(3'd3, 5'd9, 4'd3, 5'd3, 5'd4, 5'd9, INT, INT, $urandom);
    other = mk(3'd1, 5'd4, 4'd1, 5'd10, 5'd11, 5'd12, IMM, IMM, $urandom);
    applyStimulus(1'b1, m);
    iss_ready = 3'b011;
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, other);
      #1;
      checks++;
      if (iss_valid !== 3'b100) begin failures++; $display("[TB] FAIL muldiv_valid_%0d: got %b expected 100", i, iss_valid); end
      checks++;
      if (id_ready !== 1'b0) begin failures++; $display("[TB] FAIL muldiv_ready_%0d: got %b expected 0", i, id_ready); end
      checks++;
      if (dutFields() !== fieldsOf(m)) begin failures++; $display("[TB] FAIL muldiv_fields_%0d: got %h expected %h", i, dutFields(), fieldsOf(m)); end
      checks++;
      if (stall_cnt !== 16'd0) begin failures++; $display("[TB] FAIL muldiv_stall_%0d: got %0d expected 0", i, stall_cnt); end
      @(posedge clk);
      #1;
    end
    iss_ready = 3'b111;
    #1;
    checks++;
    if (id_ready !== 1'b1) begin failures++; $display("[TB] FAIL muldiv_release_ready: got %b expected 1", id_ready); end
    tick();
    applyStimulus(1'b0, other);
    #1;
    checks++;
    if (dutFields() !== fieldsOf(other)) begin failures++; $display("[TB] FAIL muldiv_next_fields: got %h expected %h", dutFields(), fieldsOf(other)); end
    checks++;
    if (sb_busy !== 32'h0000_0200) begin failures++; $display("[TB] FAIL muldiv_busy: got %h expected 00000200", sb_busy); end
  endtask

  task automatic test_flush();
    instT a;
    instT b;
    instT c;
    doReset();
    a = mk(3'd1, 5'd1, 4'd0, 5'd0, 5'd0, 5'd3, IMM, NON, 32'h11);
    b = mk(3'd2, 5'd2, 4'd2, 5'd0, 5'd0, 5'd4, NON, NON, 32'h22);
    c = mk(3'd3, 5'd3, 4'd1, 5'd0, 5'd0, 5'd8, NON, NON, 32'h33);
    iss_ready = 3'b111;
    applyStimulus(1'b1, a);
    tick();
    applyStimulus(1'b1, b);
    tick();
    applyStimulus(1'b1, c);
    flush = 1'b1;
    #1;
    checks++;
    if (iss_valid !== 3'b000) begin failures++; $display("[TB] FAIL flush_no_issue: got %b expected 000", iss_valid); end
    checks++;
    if (id_ready !== 1'b0) begin failures++; $display("[TB] FAIL flush_ready: got %b expected 0", id_ready); end
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, c);
    #1;
    checks++;
    if (iss_valid !== 3'b000) begin failures++; $display("[TB] FAIL flush_empty_valid: got %b expected 000", iss_valid); end
    checks++;
    if (id_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_empty_ready: got %b expected 1", id_ready); end
    checks++;
    if (sb_busy !== 32'h0000_0008) begin failures++; $display("[TB] FAIL flush_busy: got %h expected 00000008", sb_busy); end
  endtask

  task automatic test_set_wins();
    instT a;
    instT z;
    instT n;
    doReset();
    a = mk(3'd1, 5'd5, 4'd0, 5'd0, 5'd0, 5'd7, NON, NON, 32'h77);
    z = mk(3'd2, 5'd6, 4'd0, 5'd0, 5'd0, 5'd0, NON, NON, 32'h00);
    n = mk(3'd6, 5'd7, 4'd0, 5'd0, 5'd0, 5'd2, NON, NON, 32'h66);
    iss_ready = 3'b111;
    applyStimulus(1'b1, a);
    tick();
    applyStimulus(1'b0, a);
    wb_valid = 1'b1;
    wb_rd    = 5'd7;
    #1;
    checks++;
    if (iss_valid !== 3'b001) begin failures++; $display("[TB] FAIL setwins_fire: got %b expected 001", iss_valid); end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++;
    if (sb_busy !== 32'h0000_0080) begin failures++; $display("[TB] FAIL setwins_busy: got %h expected 00000080", sb_busy); end
    applyStimulus(1'b1, z);
    tick();
    applyStimulus(1'b0, z);
    wb_valid = 1'b1;
    wb_rd    = 5'd0;
    #1;
    checks++;
    if (iss_valid !== 3'b010) begin failures++; $display("[TB] FAIL rd0_fire: got %b expected 010", iss_valid); end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++;
    if (sb_busy !== 32'h0000_0080) begin failures++; $display("[TB] FAIL rd0_busy: got %h expected 00000080", sb_busy); end
    applyStimulus(1'b1, n);
    tick();
    applyStimulus(1'b0, n);
    #1;
    checks++;
    if ({iss_valid, id_ready} !== 4'b0001) begin failures++; $display("[TB] FAIL nonunit_retire: got %b expected 0001", {iss_valid, id_ready}); end
    tick();
    checks++;
    if (sb_busy !== 32'h0000_0080) begin failures++; $display("[TB] FAIL nonunit_busy: got %h expected 00000080", sb_busy); end
  endtask

  task automatic test_random();
    instT        inst;
    bit          v;
    bit          fl;
    bit          wv;
    logic [4:0]  wr;
    logic [2:0]  rdy;
    logic [2:0]  expIss;
    logic [31:0] nb;
    bit          haz;
    bit          fire;
    bit          retire;
    bit          expRdy;
    doReset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      v    = ($urandom_range(0, 3) != 0);
      inst = mk(3'($urandom_range(0, 7)), 5'($urandom), 4'($urandom),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom);
      rdy  = 3'($urandom_range(0, 7));
      fl   = ($urandom_range(0, 15) == 0);
      wv   = ($urandom_range(0, 2) == 0);
      wr   = 5'($urandom_range(0, 7));
      if (mBusy != 0 && $urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 32; k++) begin
          if (mBusy[k] && $urandom_range(0, 2) == 0) wr = 5'(k);
        end
      end
      applyStimulus(v, inst);
      iss_ready = rdy;
      flush     = fl;
      wb_valid  = wv;
      wb_rd     = wr;
      #1;
      haz    = mHeld && mHazard(mInst, mBusy, wv, wr);
      expIss = (mHeld && !haz && !fl && isExec(mInst.unit)) ? (3'b001 << (mInst.unit - 3'd1)) : 3'b000;
      fire   = |(expIss & rdy);
      retire = mHeld && !haz && !fl && !isExec(mInst.unit);
      expRdy = (!mHeld || fire || retire) && !fl;
      checks++;
      if (iss_valid !== expIss) begin failures++; $display("[TB] FAIL rand_iss_valid cyc %0d: got %b expected %b", cyc, iss_valid, expIss); end
      checks++;
      if (id_ready !== expRdy) begin failures++; $display("[TB] FAIL rand_id_ready cyc %0d: got %b expected %b", cyc, id_ready, expRdy); end
      checks++;
      if (sb_busy !== mBusy) begin failures++; $display("[TB] FAIL rand_sb_busy cyc %0d: got %h expected %h", cyc, sb_busy, mBusy); end
      checks++;
      if (stall_cnt !== 16'(mStall)) begin failures++; $display("[TB] FAIL rand_stall cyc %0d: got %0d expected %0d", cyc, stall_cnt, mStall); end
      checks++;
      if (dutFields() !== fieldsOf(mInst)) begin failures++; $display("[TB] FAIL rand_fields cyc %0d: got %h expected %h", cyc, dutFields(), fieldsOf(mInst)); end
      if (haz && mStall < 65535) mStall++;
      nb = mBusy;
      if (wv && wr != 5'd0) nb[wr] = 1'b0;
      if (fire && mInst.rd != 5'd0) nb[mInst.rd] = 1'b1;
      mBusy = nb;
      if (fl) begin
        mHeld = 0;
      end else if (v && expRdy) begin
        mHeld = 1;
        mInst = inst;
      end else if (fire || retire) begin
        mHeld = 0;
      end
      tick();
    end
  endtask

  task automatic test_stall_saturate();
    instT a;
    instT b;
    doReset();
    a = mk(3'd1, 5'd1, 4'd0, 5'd0, 5'd0, 5'd1, NON, NON, 32'h1);
    b = mk(3'd2, 5'd2, 4'd0, 5'd1, 5'd0, 5'd2, INT, NON, 32'h2);
    iss_ready = 3'b111;
    applyStimulus(1'b1, a);
    tick();
    applyStimulus(1'b1, b);
    tick();
    applyStimulus(1'b0, b);
    repeat (1000) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'd1000) begin failures++; $display("[TB] FAIL stall_count_1000: got %0d expected 1000", stall_cnt); end
    repeat (69000) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFF) begin failures++; $display("[TB] FAIL stall_saturate: got %h expected ffff", stall_cnt); end
    checks++;
    if (iss_valid !== 3'b000) begin failures++; $display("[TB] FAIL stall_no_issue: got %b expected 000", iss_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({iss_valid, id_ready, sb_busy, stall_cnt} !== 52'h0) begin
      failures++;
      $display("[TB] FAIL midrun_reset_outputs: got valid=%b ready=%b busy=%h stall=%h expected all 0", iss_valid, id_ready, sb_busy, stall_cnt);
    end
    checks++;
    if (dutFields() !== 60'h0) begin failures++; $display("[TB] FAIL midrun_reset_fields: got %h expected 0", dutFields()); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (id_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrun_release_ready: got %b expected 1", id_ready); end
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_wb_bypass();
    test_muldiv_backpressure();
    test_flush();
    test_set_wins();
    test_random();
    test_stall_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
